// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one multiply-accumulate unit between NUM_REQ FIR channels.
// Latency: tick at cycle 0 -> CLEAR at 2, RUN 3..NUM_TAPS+2, done_o at NUM_TAPS+3 (uncontended).
// Backpressure: none; each channel queues one tick, a further tick is dropped and flagged in overrun_o.
module mac_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_TAPS = 21,
    parameter int IDX_W    = $clog2(NUM_TAPS)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               mac_clr_o,
    output logic               mac_en_o,
    output logic [IDX_W-1:0]   tap_idx_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic               busy_o,
    output logic [NUM_REQ-1:0] overrun_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   NREQ_W   = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] TAP_LAST = IDX_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] overrun_q;
    logic [NUM_REQ-1:0] grant_clr;
    logic [NUM_REQ-1:0] owner_oh;
    logic [PTR_W-1:0]   rr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W:0]     rr_sum;
    logic               sel_vld;
    logic [IDX_W-1:0]   tap_q;

    // Cyclic search for the first pending channel at or after the round-robin pointer.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        rr_sum  = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_sum = {1'b0, rr_q} + (PTR_W+1)'(i);
            if (rr_sum >= NREQ_W) begin
                rr_sum = rr_sum - NREQ_W;
            end
            cand = rr_sum[PTR_W-1:0];
            if (!sel_vld && pending_q[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Next state and MAC control strobes, decoded from the current state and owner.
    always_comb begin
        state_d   = state_q;
        grant_clr = '0;
        owner_oh  = '0;
        owner_oh[owner_q] = 1'b1;
        grant_o   = '0;
        mac_clr_o = 1'b0;
        mac_en_o  = 1'b0;
        tap_idx_o = '0;
        done_o    = '0;
        busy_o    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    state_d            = S_CLEAR;
                    grant_clr[sel_idx] = 1'b1;
                end
            end
            S_CLEAR: begin
                grant_o   = owner_oh;
                mac_clr_o = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                grant_o   = owner_oh;
                mac_en_o  = 1'b1;
                tap_idx_o = tap_q;
                if (tap_q == TAP_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_o = owner_oh;
                done_o  = owner_oh;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner latch, round-robin pointer advance after DONE, and tap counter for RUN.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            owner_q <= '0;
            rr_q    <= '0;
            tap_q   <= '0;
        end else begin
            if (state_q == S_IDLE && sel_vld) begin
                owner_q <= sel_idx;
            end
            if (state_q == S_DONE) begin
                rr_q <= (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
            end
            tap_q <= (state_q == S_RUN && tap_q != TAP_LAST) ? tap_q + IDX_W'(1) : '0;
        end
    end

    // Pending ticks: a new tick beats the grant clear, a tick onto a still-pending one is lost.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= (pending_q & ~grant_clr) | req_i;
            overrun_q <= overrun_q | (req_i & pending_q & ~grant_clr);
        end
    end

    assign overrun_o = overrun_q;

endmodule

// File: doc/mac_arbiter.md
Name: mac_arbiter

Overview:
- Time-multiplexes one shared multiply-accumulate unit (one DSP multiplier plus accumulator, FIR-style) between NUM_REQ filter channels. This cuts DSP usage of the per-channel input/delay FIR filters.
- Each channel raises a one-cycle sample tick. The arbiter queues it, grants the MAC round-robin, and walks tap indices 0..NUM_TAPS-1.
- It emits the MAC control strobes and a per-channel done pulse. It sits between the ADC/filter tick sources and the shared MAC datapath.

Parameters:
- NUM_REQ, 4, number of requesting channels (2..8)
- NUM_TAPS, 21, MAC cycles per request (coefficient count, >=2)
- IDX_W, $clog2(NUM_TAPS), width of tap index

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- req_i  in  NUM_REQ  per-channel sample tick, one-cycle pulse
- grant_o  out  NUM_REQ  one-hot owner of the MAC; high from CLEAR through DONE
- mac_clr_o  out  1  clear accumulator; high in the CLEAR cycle only
- mac_en_o  out  1  accumulate one product this cycle; high in RUN only
- tap_idx_o  out  IDX_W  coefficient/sample index for the current RUN cycle
- done_o  out  NUM_REQ  one-cycle pulse on the served channel; accumulator result is valid
- busy_o  out  1  high whenever state is not IDLE
- overrun_o  out  NUM_REQ  sticky per channel: a tick was dropped

Behaviour:
- Reset (reset_i=0, async) forces all of the following: state IDLE, pending=0, rr_ptr=0, tap count=0, every output 0. A reset in mid-service aborts the request; no done_o is issued and the partial accumulate is discarded.
- Pending register: on each rising edge, pending[k] is set by req_i[k]. It is cleared when channel k is granted (IDLE->CLEAR).
  - If req_i[k] coincides with its own grant edge, the set wins: pending stays 1 and no overrun is flagged.
  - If req_i[k] arrives while pending[k] is already 1, the tick is dropped and overrun_o[k] is set. overrun_o stays set until reset.
  - A req_i[k] while k is in service (pending[k]=0) is legal and queues the next sample.
- State machine:
  - IDLE: if pending!=0, select the first set bit at or after rr_ptr (cyclic search), latch it as owner, then go to CLEAR. Otherwise stay in IDLE.
  - CLEAR, 1 cycle: grant_o=owner, mac_clr_o=1, tap_idx_o=0. Next state RUN.
  - RUN, NUM_TAPS cycles: mac_en_o=1, tap_idx_o counts 0..NUM_TAPS-1. The last cycle has tap_idx_o=NUM_TAPS-1. Next state DONE.
  - DONE, 1 cycle: done_o[owner]=1, grant_o held, mac_en_o=0. Set rr_ptr=(owner+1) mod NUM_REQ. Next state IDLE.
- Timing, no contention: req_i at cycle 0, pending at cycle 1, CLEAR at cycle 2, RUN at cycles 3..NUM_TAPS+2, done_o at cycle NUM_TAPS+3. With NUM_TAPS=21, done_o is at cycle 24.
- Slot time: one service occupies NUM_TAPS+3 cycles including the IDLE decision cycle. Back-to-back services have exactly one IDLE cycle between DONE and the next CLEAR.
- Invariants:
  - grant_o is zero or one-hot.
  - mac_en_o and mac_clr_o are never high together.
  - tap_idx_o is 0 outside RUN.
  - At most one done_o bit is high per cycle.
- Fairness: the round-robin pointer guarantees each pending channel is served within NUM_REQ slots.

Test Plan:
- Single pulse req_i=0001 at cycle 0, NUM_TAPS=21 -> grant_o=0001 at cycles 2..24; mac_clr_o at 2; mac_en_o at 3..23 with tap_idx_o 0..20; done_o=0001 at 24; busy_o low at 25.
- Simultaneous req_i=1010 at cycle 0 -> channel 1 served first (done at 24), IDLE at 25, channel 3 CLEAR at 26, done_o=1000 at 48, rr_ptr=0.
- Round-robin rotation: req_i=1111 every 200 cycles, three times -> done order 0,1,2,3 each time; then with rr_ptr=2 and req_i=0101 -> channel 2 before channel 0.
- Overrun: req_i[0] pulsed at cycles 0 and 1 while channel 1 is in service -> overrun_o=0001 sticky; only one done_o[0] is produced; an equal-edge set/grant on channel 2 raises no overrun.
- Self re-request: req_i[0] at cycle 10 during its own service -> second service starts at CLEAR cycle 26, second done_o at 48, no overrun.
- Reset mid-RUN: assert reset_i=0 at cycle 12 -> all outputs 0 immediately (async); no done_o; after release, a fresh req_i=0100 is served from rr_ptr=0 with latency 24.
